// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding, RV32I opcode/funct7 constants and decoded-entry type
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000,
      ALU_SUB    = 4'b0001,
      ALU_SLL    = 4'b0010,
      ALU_SRL    = 4'b0011,
      ALU_SRA    = 4'b0100,
      ALU_SLT    = 4'b0101,
      ALU_SLTU   = 4'b0110,
      ALU_XOR    = 4'b0111,
      ALU_OR     = 4'b1000,
      ALU_AND    = 4'b1001,
      ALU_PASS_B = 4'b1010
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      alu_op_e         op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic            illegal;
   } alu_entry_t;

   // Base-encoding operation selected by funct3 (funct7/imm[11:5] all zero)
   function automatic alu_op_e f3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream instruction handshake and downstream ALU-operand handshake
interface alu_issue_stage_if;
   logic                       in_valid;
   logic                       in_ready;
   logic [31:0]                instr;
   logic [alu_pkg::XLEN-1:0]   rs1_data;
   logic [alu_pkg::XLEN-1:0]   rs2_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [3:0]                 alu_op;
   logic [alu_pkg::XLEN-1:0]   op_a;
   logic [alu_pkg::XLEN-1:0]   op_b;
   logic [4:0]                 rd;
   logic                       illegal;

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_op, op_a, op_b, rd, illegal
   );

   modport master (
      output in_valid, instr, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_op, op_a, op_b, rd, illegal
   );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I OP/OP-IMM(/LUI when LUI_DECODE_EN is defined) to ALU opcode and operands
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   output alu_op_e         o_alu_op,
   output logic [XLEN-1:0] o_op_a,
   output logic [XLEN-1:0] o_op_b,
   output logic [4:0]      o_rd,
   output logic            o_illegal
);

   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic            w_shift;
   alu_op_e         w_op;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic            w_ill;

   assign w_opc   = i_instr[6:0];
   assign w_f3    = i_instr[14:12];
   assign w_f7    = i_instr[31:25];
   assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

   // Decode opcode/funct fields; anything not matched stays illegal
   always_comb begin
      w_op  = ALU_ADD;
      w_a   = '0;
      w_b   = '0;
      w_ill = 1'b1;
      case (w_opc)
         OPC_OP: begin
            w_ill = !(w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            w_op  = (w_f7 == F7_ALT) ? ((w_f3 == 3'b000) ? ALU_SUB : ALU_SRA) : f3_to_op(w_f3);
            w_a   = i_rs1_data;
            w_b   = i_rs2_data;
         end
         OPC_OP_IMM: begin
            w_ill = (w_f3 == 3'b001 && w_f7 != F7_BASE) ||
                    (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT);
            w_op  = (w_f3 == 3'b101 && w_f7 == F7_ALT) ? ALU_SRA : f3_to_op(w_f3);
            w_a   = i_rs1_data;
            w_b   = w_shift ? {27'b0, i_instr[24:20]} : {{20{i_instr[31]}}, i_instr[31:20]};
         end
`ifdef LUI_DECODE_EN
         OPC_LUI: begin
            w_ill = 1'b0;
            w_op  = ALU_PASS_B;
            w_b   = {i_instr[31:12], 12'b0};
         end
`endif
         default: ;
      endcase
   end

   // Illegal entries carry a neutral payload so downstream never sees stray operands
   assign o_alu_op  = w_ill ? ALU_ADD : w_op;
   assign o_op_a    = w_ill ? '0 : w_a;
   assign o_op_b    = w_ill ? '0 : w_b;
   assign o_rd      = w_ill ? 5'd0 : i_instr[11:7];
   assign o_illegal = w_ill;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode + two-entry skid buffer feeding the ALU (LUI decode gated by LUI_DECODE_EN)
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_stage_if.slave  io_bus
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

   state_e     r_state;
   state_e     w_next;
   logic       r_in_ready;
   logic       r_out_valid;
   alu_entry_t r_main;
   alu_entry_t r_skid;
   alu_entry_t w_dec;
   logic       w_accept;
   logic       w_drain;
   logic       w_load_main;
   logic       w_load_skid;
   logic       w_shift;

   alu_op_decode u_dec (
      .i_instr    (io_bus.instr),
      .i_rs1_data (io_bus.rs1_data),
      .i_rs2_data (io_bus.rs2_data),
      .o_alu_op   (w_dec.op),
      .o_op_a     (w_dec.a),
      .o_op_b     (w_dec.b),
      .o_rd       (w_dec.rd),
      .o_illegal  (w_dec.illegal)
   );

   assign w_accept = io_bus.in_valid && r_in_ready;
   assign w_drain  = r_out_valid && io_bus.out_ready;

   // Next buffer state and which register loads this cycle
   always_comb begin
      w_next      = r_state;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         S_EMPTY: begin
            w_load_main = w_accept;
            w_next      = w_accept ? S_ONE : S_EMPTY;
         end
         S_ONE: begin
            w_load_main = w_accept && w_drain;
            w_load_skid = w_accept && !w_drain;
            w_next      = w_load_skid ? S_FULL : (w_drain && !w_accept) ? S_EMPTY : S_ONE;
         end
         S_FULL: begin
            w_shift = w_drain;
            w_next  = w_drain ? S_ONE : S_FULL;
         end
         default: w_next = S_EMPTY;
      endcase
   end

   // State register; handshake flags registered so in_ready never sees out_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next != S_FULL);
         r_out_valid <= (w_next != S_EMPTY);
      end
   end

   // Entry storage: main feeds the outputs, skid catches the entry accepted while main stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main)
            r_main <= w_dec;
         else if (w_shift)
            r_main <= r_skid;
         if (w_load_skid)
            r_skid <= w_dec;
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.alu_op    = r_main.op;
   assign io_bus.op_a      = r_main.a;
   assign io_bus.op_b      = r_main.b;
   assign io_bus.rd        = r_main.rd;
   assign io_bus.illegal   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_pop = 0;
   logic [79:0] q[$];
   logic [79:0] exp_cur;
   logic        p_valid = 1'b0;
   logic        p_ready = 1'b0;
   logic [79:0] p_out = '0;

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] ent(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rd, input logic il);
      return {6'b0, op, a, b, rd, il};
   endfunction

   function automatic logic [79:0] obs();
      return ent(bus.alu_op, bus.op_a, bus.op_b, bus.rd, bus.illegal);
   endfunction

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic [79:0] e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.instr    = ins;
      bus.rs1_data = r1;
      bus.rs2_data = r2;
      exp_cur      = e;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("drain_timeout", 80'(q.size() == 0), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_add(input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
      logic [4:0] r1;
      logic [4:0] r2;
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      send({7'b0, r2, r1, 3'b000, rd, 7'b0110011}, d1, d2, ent(4'h0, d1, d2, rd, 1'b0));
   endtask

   // Output monitor: pop on drain, enforce stability under stall, push on accept
   always @(negedge clk) begin
      logic [79:0] cur;
      cur = obs();
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) chk("spurious", 1, 0);
         else chk("entry", cur, q.pop_front());
         n_pop++;
      end
      if (rst_n && bus.out_valid && p_valid && !p_ready) chk("hold", cur, p_out);
      if (rst_n && bus.in_valid && bus.in_ready) q.push_back(exp_cur);
      p_valid = rst_n && bus.out_valid;
      p_ready = bus.out_ready;
      p_out   = cur;
   end

   initial begin
      int snap;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      bus.out_ready = 1'b0;
      exp_cur       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hs", {78'b0, bus.in_ready, bus.out_valid}, 2'b10);
      chk("rst_out", obs(), ent(4'h0, 0, 0, 5'd0, 1'b0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      chk("lat_before", 80'(bus.out_valid), 0);
      send(32'h002081B3, 32'd5, 32'd3, ent(4'h0, 32'd5, 32'd3, 5'd3, 1'b0));
      chk("lat_after", 80'(bus.out_valid), 1);
      send(32'hFFF00093, 32'd7, 32'd1, ent(4'h0, 32'd7, 32'hFFFFFFFF, 5'd1, 1'b0));
      send(32'h4040D093, 32'h80000000, 32'd9, ent(4'h4, 32'h80000000, 32'd4, 5'd1, 1'b0));
      send(32'h0030D113, 32'h12, 32'd9, ent(4'h3, 32'h12, 32'd3, 5'd2, 1'b0));
      send(32'hF0F1F113, 32'hAA, 32'd9, ent(4'h9, 32'hAA, 32'hFFFFFF0F, 5'd2, 1'b0));
      send(32'h407302B3, 32'd10, 32'd4, ent(4'h1, 32'd10, 32'd4, 5'd5, 1'b0));
`ifdef LUI_DECODE_EN
      send(32'h123452B7, 32'd9, 32'd9, ent(4'hA, 32'd0, 32'h12345000, 5'd5, 1'b0));
`else
      send(32'h123452B7, 32'd9, 32'd9, ent(4'h0, 32'd0, 32'd0, 5'd0, 1'b1));
`endif
      send(32'h020000B3, 32'd9, 32'd9, ent(4'h0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h400010B3, 32'd9, 32'd9, ent(4'h0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h40001093, 32'd9, 32'd9, ent(4'h0, 32'd0, 32'd0, 5'd0, 1'b1));
      for (int i = 0; i < 8; i++) send_add(5'(i + 10), $urandom, $urandom);
      drain();
      // Backpressure: two accepted, third stalls, then all three emerge back to back
      bus.out_ready = 1'b0;
      send_add(5'd21, 32'h1, 32'h2);
      send_add(5'd22, 32'h3, 32'h4);
      fork
         send_add(5'd23, 32'h5, 32'h6);
         begin
            repeat (2) begin
               @(negedge clk);
               chk("full_in_ready", 80'(bus.in_ready), 0);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("nogap", 80'(bus.out_valid), 1);
            end
         end
      join
      drain();
      // Random out_ready pattern with continuous input
      fork
         for (int i = 0; i < 20; i++) send_add(5'(i), $urandom, $urandom);
         repeat (60) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
         end
      join
      drain();
      // Asynchronous reset while FULL
      bus.out_ready = 1'b0;
      send_add(5'd7, 32'h11, 32'h22);
      send_add(5'd8, 32'h33, 32'h44);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_hs", {78'b0, bus.in_ready, bus.out_valid}, 2'b10);
      chk("arst_out", obs(), ent(4'h0, 0, 0, 5'd0, 1'b0));
      q.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      snap = n_pop;
      bus.out_ready = 1'b1;
      send_add(5'd9, 32'h55, 32'h66);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("alone", 80'(n_pop - snap), 1);
      chk("idle", 80'(bus.out_valid), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
